vote_recorder: RTL and testbench

Ballot-control and tally stage directly downstream of the four per-candidate button-qualification stages. Accepts one-cycle `vote_valid` pulses, enforces one vote per armed ballot, keeps saturating per-candidate and total counts, and presents a selected candidate's count in result mode. Drives the confirm LEDs and the ballot-open indicator on the front panel.

---
 rtl/vote_recorder.sv | 158 +++++++++++++++
 tb/tb_vote_recorder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_recorder.sv
// Ballot control and saturating per-candidate tally for a four-candidate voting panel.
// Define VOTE_LOCKOUT_EN to require a ballot_arm pulse before every vote; otherwise ballots reopen automatically.
module vote_recorder #(
    parameter int COUNT_W        = 8,
    parameter int CONFIRM_CYCLES = 50000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               ballot_arm,
    input  logic [3:0]         vote_valid,
    input  logic [1:0]         cand_sel,
    output logic               ballot_open,
    output logic               vote_ack,
    output logic               vote_reject,
    output logic [3:0]         confirm_led,
    output logic [COUNT_W-1:0] vote_count,
    output logic [COUNT_W-1:0] total_votes
);

    localparam logic [1:0] ST_CLOSED  = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;

    localparam int                 TIMER_W    = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CONFIRM_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_ballot_open;
    logic               r_vote_ack;
    logic               r_vote_reject;
    logic [3:0]         r_confirm_led;
    logic [COUNT_W-1:0] r_count [4];
    logic [COUNT_W-1:0] r_total;
    logic [COUNT_W-1:0] r_vote_count;

    logic [1:0]         w_next_state;
    logic [TIMER_W-1:0] w_timer_next;
    logic               w_accept;
    logic               w_reject;
    logic               w_led_clear;
    logic               w_one_hot;
    logic               w_multi;
    logic               w_open_req;
    logic [1:0]         w_after_confirm;

    // Clearing the lowest set bit leaves something only when two or more buttons fired together.
    assign w_multi   = (vote_valid & (vote_valid - 4'd1)) != 4'd0;
    assign w_one_hot = (vote_valid != 4'd0) && !w_multi;

`ifdef VOTE_LOCKOUT_EN
    assign w_open_req      = ballot_arm;
    assign w_after_confirm = ST_CLOSED;
`else
    // The officer pulse has no role when ballots reopen on their own.
    logic w_unused_arm;
    assign w_unused_arm    = ballot_arm;
    assign w_open_req      = 1'b1;
    assign w_after_confirm = ST_OPEN;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the branches so no path leaves one unassigned (no latches).
        w_next_state = r_state;
        w_timer_next = r_timer;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_led_clear  = 1'b0;

        if (mode) begin
            w_next_state = ST_CLOSED;
            w_timer_next = '0;
            w_led_clear  = 1'b1;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (w_open_req) begin
                        w_next_state = ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (w_one_hot) begin
                        w_accept     = 1'b1;
                        w_timer_next = TIMER_LOAD;
                        w_next_state = ST_CONFIRM;
                    end else if (w_multi) begin
                        w_reject = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (r_timer == '0) begin
                        w_led_clear  = 1'b1;
                        w_next_state = w_after_confirm;
                    end else begin
                        w_timer_next = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_CLOSED;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state       <= ST_CLOSED;
            r_timer       <= '0;
            r_ballot_open <= 1'b0;
            r_vote_ack    <= 1'b0;
            r_vote_reject <= 1'b0;
            r_confirm_led <= 4'd0;
            r_total       <= '0;
            r_vote_count  <= '0;
            // NOTE: the tally array is reset explicitly; it is a small register file, not inferred RAM.
            for (int i = 0; i < 4; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_timer_next;
            r_ballot_open <= (w_next_state == ST_OPEN);
            r_vote_ack    <= w_accept;
            r_vote_reject <= w_reject;

            if (w_accept) begin
                r_confirm_led <= vote_valid;
            end else if (w_led_clear) begin
                r_confirm_led <= 4'd0;
            end

            // A saturated candidate still acknowledges; only the count stops moving.
            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    if (vote_valid[i] && (r_count[i] != COUNT_MAX)) begin
                        r_count[i] <= r_count[i] + 1'b1;
                    end
                end
                if (r_total != COUNT_MAX) begin
                    r_total <= r_total + 1'b1;
                end
            end

            r_vote_count <= mode ? r_count[cand_sel] : '0;
        end
    end

    assign ballot_open = r_ballot_open;
    assign vote_ack    = r_vote_ack;
    assign vote_reject = r_vote_reject;
    assign confirm_led = r_confirm_led;
    assign vote_count  = r_vote_count;
    assign total_votes = r_total;

endmodule

// File: tb/tb_vote_recorder.sv
// Self-checking bench for vote_recorder: per-cycle comparison against a behavioural ballot model,
// plus directed scenarios with hand-computed expectations. Adapts to VOTE_LOCKOUT_EN.
module tb_vote_recorder;

    localparam int CW     = 2;
    localparam int CONF   = 4;
    localparam int MAXV   = (1 << CW) - 1;
`ifdef VOTE_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          mode;
    logic          ballot_arm;
    logic [3:0]    vote_valid;
    logic [1:0]    cand_sel;
    logic          ballot_open;
    logic          vote_ack;
    logic          vote_reject;
    logic [3:0]    confirm_led;
    logic [CW-1:0] vote_count;
    logic [CW-1:0] total_votes;

    int checks = 0;
    int errors = 0;
    int acks   = 0;

    vote_recorder #(
        .COUNT_W       (CW),
        .CONFIRM_CYCLES(CONF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mode       (mode),
        .ballot_arm (ballot_arm),
        .vote_valid (vote_valid),
        .cand_sel   (cand_sel),
        .ballot_open(ballot_open),
        .vote_ack   (vote_ack),
        .vote_reject(vote_reject),
        .confirm_led(confirm_led),
        .vote_count (vote_count),
        .total_votes(total_votes)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Ballot model: lit_left counts the confirm-LED cycles still to show; no lit cycles and not open means closed.
    typedef struct packed {
        logic            valid;
        logic            open;
        logic [7:0]      lit_left;
        logic [3:0]      led;
        logic            ack;
        logic            rej;
        logic [3:0][7:0] cnt;
        logic [7:0]      total;
        logic [7:0]      vcount;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(model_t cur, logic rst, logic md, logic arm,
                                          logic [3:0] vv, logic [1:0] sel);
        model_t n;
        n     = cur;
        n.ack = 1'b0;
        n.rej = 1'b0;
        if (rst) begin
            n       = '0;
            n.valid = 1'b1;
            return n;
        end
        n.vcount = md ? cur.cnt[sel] : 8'd0;
        if (md) begin
            n.open     = 1'b0;
            n.lit_left = 8'd0;
            n.led      = 4'd0;
        end else if (cur.lit_left != 8'd0) begin
            n.lit_left = cur.lit_left - 8'd1;
            if (n.lit_left == 8'd0) begin
                n.led  = 4'd0;
                n.open = !LOCK;
            end
        end else if (cur.open) begin
            case ($countones(vv))
                0: ;
                1: begin
                    for (int i = 0; i < 4; i++) begin
                        if (vv[i] && (int'(cur.cnt[i]) < MAXV)) n.cnt[i] = cur.cnt[i] + 8'd1;
                    end
                    if (int'(cur.total) < MAXV) n.total = cur.total + 8'd1;
                    n.ack      = 1'b1;
                    n.led      = vv;
                    n.lit_left = 8'(CONF);
                    n.open     = 1'b0;
                end
                default: n.rej = 1'b1;
            endcase
        end else begin
            n.open = LOCK ? arm : 1'b1;
        end
        return n;
    endfunction

    always @(posedge clock) begin
        m <= model_next(m, reset, mode, ballot_arm, vote_valid, cand_sel);
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m.valid) begin
            check("cmp_ballot_open", int'(ballot_open), int'(m.open));
            check("cmp_vote_ack",    int'(vote_ack),    int'(m.ack));
            check("cmp_vote_reject", int'(vote_reject), int'(m.rej));
            check("cmp_confirm_led", int'(confirm_led), int'(m.led));
            check("cmp_vote_count",  int'(vote_count),  int'(m.vcount));
            check("cmp_total_votes", int'(total_votes), int'(m.total));
        end
    end

    if (1) begin : g_watchdog
        initial begin
            #200000;
            $display("FAIL watchdog: bench did not complete within time limit");
            $fatal(1, "watchdog expired");
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One reset edge must clear every output.
    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        check("rst_ballot_open", int'(ballot_open), 0);
        check("rst_vote_ack",    int'(vote_ack),    0);
        check("rst_vote_reject", int'(vote_reject), 0);
        check("rst_confirm_led", int'(confirm_led), 0);
        check("rst_vote_count",  int'(vote_count),  0);
        check("rst_total_votes", int'(total_votes), 0);
        reset = 1'b0;
    endtask

    task automatic arm();
        ballot_arm = 1'b1;
        tick(1);
        ballot_arm = 1'b0;
        check("arm_ballot_open", int'(ballot_open), 1);
    endtask

    task automatic vote(input logic [3:0] v);
        vote_valid = v;
        tick(1);
        vote_valid = 4'd0;
        if (vote_ack) acks++;
    endtask

    task automatic cast_vote(input logic [3:0] v);
        arm();
        vote(v);
        check("cast_ack", int'(vote_ack), 1);
        tick(CONF);
    endtask

    task automatic read_count(input logic [1:0] sel, input int expected);
        mode     = 1'b1;
        cand_sel = sel;
        tick(1);
        check("read_vote_count", int'(vote_count), expected);
    endtask

    initial begin
        reset      = 1'b1;
        mode       = 1'b0;
        ballot_arm = 1'b0;
        vote_valid = 4'd0;
        cand_sel   = 2'd0;

        // Single vote for candidate 1, confirm window, then lockout behaviour.
        do_reset();
        arm();
        vote(4'b0010);
        check("a_ack",         int'(vote_ack),    1);
        check("a_led",         int'(confirm_led), 2);
        check("a_open_fall",   int'(ballot_open), 0);
        check("a_total",       int'(total_votes), 1);
        tick(1);
        check("a_ack_once",    int'(vote_ack),    0);
        tick(2);
        check("a_led_last",    int'(confirm_led), 2);
        tick(1);
        check("a_led_clear",   int'(confirm_led), 0);
        check("a_open_after",  int'(ballot_open), LOCK ? 0 : 1);
        vote(4'b0010);
        check("a_rearm_ack",   int'(vote_ack),    LOCK ? 0 : 1);
        tick(CONF);
        read_count(2'd1, LOCK ? 1 : 2);
        check("a_total_final", int'(total_votes), LOCK ? 1 : 2);
        mode = 1'b0;
        tick(1);
        check("a_count_voting", int'(vote_count), 0);

        // Multi-candidate pulse is rejected, then a clean vote lands.
        do_reset();
        arm();
        vote(4'b0110);
        check("b_reject",      int'(vote_reject), 1);
        check("b_no_ack",      int'(vote_ack),    0);
        check("b_still_open",  int'(ballot_open), 1);
        check("b_total_same",  int'(total_votes), 0);
        tick(1);
        check("b_reject_once", int'(vote_reject), 0);
        vote(4'b0100);
        check("b_ack",         int'(vote_ack),    1);
        tick(CONF);
        read_count(2'd2, 1);
        mode = 1'b0;

        // Five votes for candidate 0 saturate the 2-bit counters.
        do_reset();
        acks = 0;
        for (int i = 0; i < 5; i++) cast_vote(4'b0001);
        check("c_acks",  acks, 5);
        read_count(2'd0, 3);
        check("c_total", int'(total_votes), 3);
        mode = 1'b0;

        // Votes 2/0/1/3 across candidates, then a cand_sel sweep in result mode.
        do_reset();
        cast_vote(4'b0001);
        cast_vote(4'b0001);
        cast_vote(4'b0100);
        for (int i = 0; i < 3; i++) cast_vote(4'b1000);
        read_count(2'd0, 2);
        read_count(2'd1, 0);
        read_count(2'd2, 1);
        read_count(2'd3, 3);
        check("d_total_sat", int'(total_votes), 3);
        mode = 1'b0;
        tick(1);
        check("d_count_zero", int'(vote_count), 0);

        // Result mode discards an open ballot.
        do_reset();
        arm();
        mode = 1'b1;
        tick(1);
        check("e_discard_open", int'(ballot_open), 0);
        mode = 1'b0;
        tick(1);
        check("e_reopen", int'(ballot_open), LOCK ? 0 : 1);
        vote(4'b0001);
        check("e_ack", int'(vote_ack), LOCK ? 0 : 1);
        tick(CONF);

        // Result mode mid-confirm clears the LED but keeps counts; reset mid-confirm clears all.
        do_reset();
        arm();
        vote(4'b1000);
        tick(1);
        mode     = 1'b1;
        cand_sel = 2'd3;
        tick(1);
        check("f_led_cleared", int'(confirm_led), 0);
        check("f_count_kept",  int'(vote_count),  1);
        mode = 1'b0;
        tick(1);
        arm();
        vote(4'b1000);
        check("f_led_set", int'(confirm_led), 8);
        tick(1);
        do_reset();
        read_count(2'd3, 0);
        mode = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
